active_list_rob: RTL and testbench

// - Parametrised in-order active list (reorder buffer) between rename/map table and regfile/memory commit.
// - Allocates one entry per dispatched instruction, holding the new and previous physical mappings.
// - Marks entries done from NUM_WB writeback ports and retires the head in order.
// - On flush, walks back from tail and returns previous mappings to the map table.

---
 rtl/active_list_pkg.sv | 30 +++
 rtl/active_list_ptr.sv | 29 ++
 rtl/active_list_rob.sv | 207 ++++++++++++++++++++
 tb/tb_active_list_rob.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/active_list_pkg.sv
// Shared types and default widths for the active list (reorder buffer).
// Optional feature macro: ACTIVE_LIST_MEM_COMMIT_EN adds store address/data fields to each entry.
package active_list_pkg;

  localparam int AL_DEPTH  = 32;
  localparam int AL_NUM_WB = 2;
  localparam int AL_LREG_W = 5;
  localparam int AL_PREG_W = 6;
  localparam int AL_ADDR_W = 32;
  localparam int AL_DATA_W = 32;

  typedef enum logic {
    AL_RUN      = 1'b0,
    AL_ROLLBACK = 1'b1
  } al_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [AL_LREG_W-1:0] lreg;
    logic [AL_PREG_W-1:0] new_preg;
    logic [AL_PREG_W-1:0] prev_preg;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
    logic                 is_store;
    logic [AL_ADDR_W-1:0] mem_addr;
    logic [AL_DATA_W-1:0] data;
`endif
  } al_entry_t;

endpackage

// File: rtl/active_list_ptr.sv
// Circular queue pointer with a wrap bit above the index bits.
// Increment and decrement in the same cycle cancel; load has priority.
module active_list_ptr #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [TAG_W:0]   load_val,
  output logic [TAG_W:0]   ptr
);

  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc && !dec) begin
      ptr <= ptr + PTR_ONE;
    end else if (dec && !inc) begin
      ptr <= ptr - PTR_ONE;
    end
  end

endmodule

// File: rtl/active_list_rob.sv
// In-order active list: allocates at tail, completes from writeback ports, retires at head,
// and rolls back youngest-first on flush. Optional feature macro: ACTIVE_LIST_MEM_COMMIT_EN.
module active_list_rob
  import active_list_pkg::*;
#(
  parameter int  DEPTH  = AL_DEPTH,
  parameter int  NUM_WB = AL_NUM_WB,
  parameter int  LREG_W = AL_LREG_W,
  parameter int  PREG_W = AL_PREG_W,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [LREG_W-1:0]       disp_lreg,
  input  logic [PREG_W-1:0]       disp_new_preg,
  input  logic [PREG_W-1:0]       disp_prev_preg,
  output logic [TAG_W-1:0]        disp_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  output logic                    commit_valid,
  input  logic                    commit_ready,
  output logic [LREG_W-1:0]       commit_lreg,
  output logic [PREG_W-1:0]       commit_new_preg,
  output logic [PREG_W-1:0]       commit_prev_preg,
  input  logic                    flush,
  input  logic [TAG_W-1:0]        flush_tag,
  output logic                    rb_valid,
  output logic [LREG_W-1:0]       rb_lreg,
  output logic [PREG_W-1:0]       rb_prev_preg,
  output logic [PREG_W-1:0]       rb_new_preg,
  output logic                    empty,
  output logic                    full
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
  ,
  input  logic                    disp_is_store,
  input  logic [AL_ADDR_W-1:0]    disp_mem_addr,
  input  logic [NUM_WB*AL_DATA_W-1:0] wb_data,
  output logic                    commit_is_store,
  output logic [AL_ADDR_W-1:0]    commit_mem_addr,
  output logic [AL_DATA_W-1:0]    commit_data
`endif
);

  // Entry storage is typed by the package struct, so the register widths must match it.
  if (LREG_W != AL_LREG_W || PREG_W != AL_PREG_W) begin : g_width_check
    $error("active_list_rob: LREG_W/PREG_W must match active_list_pkg entry widths");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("active_list_rob: DEPTH must be a power of two and at least 4");
  end

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   PTR_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  al_state_e        state, state_nxt;
  al_entry_t        mem [DEPTH];
  logic [TAG_W:0]   head, tail, count;
  logic [TAG_W-1:0] head_idx, tail_idx, last_idx, flush_tag_q;
  logic             disp_fire, commit_fire, flush_go, rb_last;

  assign count    = tail - head;
  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign last_idx = tail_idx - TAG_ONE;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign disp_tag = tail_idx;

  // Flush takes the cycle: no allocation or retirement alongside it.
  assign disp_fire   = disp_valid && disp_ready && !flush;
  assign commit_fire = commit_valid && commit_ready && !flush;
  assign flush_go    = flush && (state == AL_RUN) && !empty && (flush_tag != last_idx);
  assign rb_last     = ((last_idx - TAG_ONE) == flush_tag_q) || (count == PTR_ONE);

  active_list_ptr #(.TAG_W(TAG_W)) u_head (
    .clk      (clk),
    .rst      (rst),
    .inc      (commit_fire),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head)
  );

  active_list_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk      (clk),
    .rst      (rst),
    .inc      (disp_fire),
    .dec      (rb_valid),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AL_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AL_RUN:      if (flush_go) state_nxt = AL_ROLLBACK;
      AL_ROLLBACK: if (!rb_valid || rb_last) state_nxt = AL_RUN;
      default:     state_nxt = AL_RUN;
    endcase
  end

  always_comb begin
    disp_ready   = 1'b0;
    commit_valid = 1'b0;
    rb_valid     = 1'b0;
    if (state == AL_RUN) begin
      disp_ready   = !full;
      commit_valid = !empty && mem[head_idx].valid && mem[head_idx].done;
    end else begin
      rb_valid     = !empty;
    end
  end

  always_ff @(posedge clk) begin
    if (flush_go) begin
      flush_tag_q <= flush_tag;
    end
  end

  // Only valid/done are reset; payload fields are qualified by them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].done  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid[p] && mem[wb_tag[p*TAG_W +: TAG_W]].valid) begin
          mem[wb_tag[p*TAG_W +: TAG_W]].done <= 1'b1;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
          mem[wb_tag[p*TAG_W +: TAG_W]].data <= wb_data[p*AL_DATA_W +: AL_DATA_W];
`endif
        end
      end
      if (commit_fire) begin
        mem[head_idx].valid <= 1'b0;
      end
      // Squash wins over a same-cycle writeback to the popped entry.
      if (rb_valid) begin
        mem[last_idx].valid <= 1'b0;
        mem[last_idx].done  <= 1'b0;
      end
      if (disp_fire) begin
        mem[tail_idx].valid     <= 1'b1;
        mem[tail_idx].done      <= 1'b0;
        mem[tail_idx].lreg      <= disp_lreg;
        mem[tail_idx].new_preg  <= disp_new_preg;
        mem[tail_idx].prev_preg <= disp_prev_preg;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
        mem[tail_idx].is_store  <= disp_is_store;
        mem[tail_idx].mem_addr  <= disp_mem_addr;
`endif
      end
    end
  end

  always_comb begin
    commit_lreg      = '0;
    commit_new_preg  = '0;
    commit_prev_preg = '0;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
    commit_is_store  = 1'b0;
    commit_mem_addr  = '0;
    commit_data      = '0;
`endif
    if (commit_valid) begin
      commit_lreg      = mem[head_idx].lreg;
      commit_new_preg  = mem[head_idx].new_preg;
      commit_prev_preg = mem[head_idx].prev_preg;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
      // Stores own no register mapping, so nothing goes back to the free list.
      commit_is_store  = mem[head_idx].is_store;
      commit_mem_addr  = mem[head_idx].mem_addr;
      commit_data      = mem[head_idx].data;
      if (mem[head_idx].is_store) begin
        commit_prev_preg = '0;
      end
`endif
    end
  end

  always_comb begin
    rb_lreg      = '0;
    rb_prev_preg = '0;
    rb_new_preg  = '0;
    if (rb_valid) begin
      rb_lreg      = mem[last_idx].lreg;
      rb_prev_preg = mem[last_idx].prev_preg;
      rb_new_preg  = mem[last_idx].new_preg;
    end
  end

endmodule

// File: tb/tb_active_list_rob.sv
// Directed bench for active_list_rob: fill, out-of-order completion, dual writeback, flush, wrap.
// Memory-commit checks are built when ACTIVE_LIST_MEM_COMMIT_EN is defined.
module tb_active_list_rob;
  import active_list_pkg::*;

  localparam int DEPTH  = 32;
  localparam int NUM_WB = 2;
  localparam int TAG_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [4:0]              disp_lreg;
  logic [5:0]              disp_new_preg;
  logic [5:0]              disp_prev_preg;
  logic [TAG_W-1:0]        disp_tag;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic                    commit_valid;
  logic                    commit_ready;
  logic [4:0]              commit_lreg;
  logic [5:0]              commit_new_preg;
  logic [5:0]              commit_prev_preg;
  logic                    flush;
  logic [TAG_W-1:0]        flush_tag;
  logic                    rb_valid;
  logic [4:0]              rb_lreg;
  logic [5:0]              rb_prev_preg;
  logic [5:0]              rb_new_preg;
  logic                    empty;
  logic                    full;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
  logic                    disp_is_store;
  logic [31:0]             disp_mem_addr;
  logic [NUM_WB*32-1:0]    wb_data;
  logic                    commit_is_store;
  logic [31:0]             commit_mem_addr;
  logic [31:0]             commit_data;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  active_list_rob #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .LREG_W(5), .PREG_W(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .disp_valid       (disp_valid),
    .disp_ready       (disp_ready),
    .disp_lreg        (disp_lreg),
    .disp_new_preg    (disp_new_preg),
    .disp_prev_preg   (disp_prev_preg),
    .disp_tag         (disp_tag),
    .wb_valid         (wb_valid),
    .wb_tag           (wb_tag),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_lreg      (commit_lreg),
    .commit_new_preg  (commit_new_preg),
    .commit_prev_preg (commit_prev_preg),
    .flush            (flush),
    .flush_tag        (flush_tag),
    .rb_valid         (rb_valid),
    .rb_lreg          (rb_lreg),
    .rb_prev_preg     (rb_prev_preg),
    .rb_new_preg      (rb_new_preg),
    .empty            (empty),
    .full             (full)
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
    ,
    .disp_is_store    (disp_is_store),
    .disp_mem_addr    (disp_mem_addr),
    .wb_data          (wb_data),
    .commit_is_store  (commit_is_store),
    .commit_mem_addr  (commit_mem_addr),
    .commit_data      (commit_data)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic dispatch(input int lreg, input int newp, input int prevp);
    disp_valid     = 1'b1;
    disp_lreg      = 5'(lreg);
    disp_new_preg  = 6'(newp);
    disp_prev_preg = 6'(prevp);
    step();
    disp_valid     = 1'b0;
  endtask

  task automatic wb_one(input int tag);
    wb_valid = 2'b01;
    wb_tag   = {5'd0, 5'(tag)};
    step();
    wb_valid = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, exp finish within time limit");
    $fatal(1);
  end

  initial begin
    disp_valid = 1'b0; disp_lreg = '0; disp_new_preg = '0; disp_prev_preg = '0;
    wb_valid = '0; wb_tag = '0; commit_ready = 1'b0; flush = 1'b0; flush_tag = '0;
`ifdef ACTIVE_LIST_MEM_COMMIT_EN
    disp_is_store = 1'b0; disp_mem_addr = '0; wb_data = '0;
`endif

    // Reset state
    do_reset();
    check_eq("rst_ready", disp_ready, 1);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_cvalid", commit_valid, 0);
    check_eq("rst_rbvalid", rb_valid, 0);
    check_eq("rst_tag", disp_tag, 0);
    check_eq("rst_clreg", commit_lreg, 0);

    // T1: fill to full
    for (int i = 0; i < 32; i++) begin
      check_eq("t1_tag", disp_tag, i);
      dispatch(i, i + 32, i);
    end
    check_eq("t1_full", full, 1);
    check_eq("t1_ready", disp_ready, 0);
    check_eq("t1_cvalid", commit_valid, 0);
    check_eq("t1_empty", empty, 0);

    // T5b: dispatch and commit together while full -> dispatch blocked
    wb_one(0);
    check_eq("t5b_cvalid", commit_valid, 1);
    check_eq("t5b_clreg", commit_lreg, 0);
    check_eq("t5b_cnew", commit_new_preg, 32);
    commit_ready = 1'b1;
    disp_valid   = 1'b1;
    step();
    commit_ready = 1'b0;
    disp_valid   = 1'b0;
    check_eq("t5b_full_after", full, 0);
    check_eq("t5b_ready_after", disp_ready, 1);
    check_eq("t5b_tag_after", disp_tag, 0);
    check_eq("t5b_cvalid_after", commit_valid, 0);

    // T2: out-of-order completion, in-order commit
    do_reset();
    dispatch(1, 10, 20);
    dispatch(2, 11, 21);
    dispatch(3, 12, 22);
    commit_ready = 1'b1;
    wb_one(2);
    check_eq("t2_cv_after_wb2", commit_valid, 0);
    wb_one(0);
    check_eq("t2_cv_after_wb0", commit_valid, 1);
    check_eq("t2_c0_lreg", commit_lreg, 1);
    check_eq("t2_c0_new", commit_new_preg, 10);
    check_eq("t2_c0_prev", commit_prev_preg, 20);
    wb_one(1);
    check_eq("t2_c1_valid", commit_valid, 1);
    check_eq("t2_c1_lreg", commit_lreg, 2);
    step();
    check_eq("t2_c2_valid", commit_valid, 1);
    check_eq("t2_c2_lreg", commit_lreg, 3);
    check_eq("t2_c2_prev", commit_prev_preg, 22);
    step();
    check_eq("t2_end_cv", commit_valid, 0);
    check_eq("t2_end_empty", empty, 1);

    // T3: dual writeback, same tag then distinct tags
    commit_ready = 1'b0;
    check_eq("t3_tag0", disp_tag, 3);
    dispatch(4, 13, 23);
    dispatch(5, 14, 24);
    dispatch(6, 15, 25);
    wb_valid = 2'b11;
    wb_tag   = {5'd3, 5'd3};
    step();
    wb_tag   = {5'd5, 5'd4};
    step();
    wb_valid = 2'b00;
    check_eq("t3_c3_valid", commit_valid, 1);
    check_eq("t3_c3_lreg", commit_lreg, 4);
    commit_ready = 1'b1;
    step();
    check_eq("t3_c4_valid", commit_valid, 1);
    check_eq("t3_c4_lreg", commit_lreg, 5);
    step();
    check_eq("t3_c5_valid", commit_valid, 1);
    check_eq("t3_c5_new", commit_new_preg, 15);
    step();
    commit_ready = 1'b0;
    check_eq("t3_end_empty", empty, 1);

    // T4: flush with flush_tag=2 over six entries
    do_reset();
    for (int i = 0; i < 6; i++) dispatch(i + 8, i + 40, i + 16);
    wb_one(0);
    flush     = 1'b1;
    flush_tag = 5'd2;
    step();
    flush_tag = 5'd0;
    check_eq("t4_rb5_valid", rb_valid, 1);
    check_eq("t4_rb5_lreg", rb_lreg, 13);
    check_eq("t4_rb5_new", rb_new_preg, 45);
    check_eq("t4_rb5_prev", rb_prev_preg, 21);
    check_eq("t4_rb_ready", disp_ready, 0);
    check_eq("t4_rb_cvalid", commit_valid, 0);
    step();
    flush = 1'b0;
    check_eq("t4_rb4_valid", rb_valid, 1);
    check_eq("t4_rb4_lreg", rb_lreg, 12);
    step();
    check_eq("t4_rb3_valid", rb_valid, 1);
    check_eq("t4_rb3_lreg", rb_lreg, 11);
    check_eq("t4_rb3_new", rb_new_preg, 43);
    step();
    check_eq("t4_run_rbvalid", rb_valid, 0);
    check_eq("t4_run_ready", disp_ready, 1);
    check_eq("t4_run_tag", disp_tag, 3);
    check_eq("t4_run_cvalid", commit_valid, 1);
    dispatch(20, 60, 30);
    check_eq("t4_next_tag", disp_tag, 4);

    // T5: wrap-around and rollback across index 0
    do_reset();
    commit_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      dispatch(i, i, i);
      wb_one(i);
      step();
    end
    commit_ready = 1'b0;
    check_eq("t5_empty", empty, 1);
    check_eq("t5_tag30", disp_tag, 30);
    for (int k = 0; k < 4; k++) begin
      check_eq("t5_wrap_tag", disp_tag, (30 + k) % 32);
      dispatch(k, k + 50, k + 7);
    end
    flush     = 1'b1;
    flush_tag = 5'd31;
    step();
    flush     = 1'b0;
    check_eq("t5_rb1_valid", rb_valid, 1);
    check_eq("t5_rb1_lreg", rb_lreg, 3);
    check_eq("t5_rb1_new", rb_new_preg, 53);
    check_eq("t5_rb1_prev", rb_prev_preg, 10);
    step();
    check_eq("t5_rb0_valid", rb_valid, 1);
    check_eq("t5_rb0_lreg", rb_lreg, 2);
    check_eq("t5_rb0_new", rb_new_preg, 52);
    step();
    check_eq("t5_run_rbvalid", rb_valid, 0);
    check_eq("t5_run_ready", disp_ready, 1);
    check_eq("t5_run_tag", disp_tag, 0);

`ifdef ACTIVE_LIST_MEM_COMMIT_EN
    // T6: store commit carries address and writeback data, frees no register
    do_reset();
    disp_is_store = 1'b1;
    disp_mem_addr = 32'h0000_1000;
    dispatch(3, 9, 7);
    disp_is_store = 1'b0;
    disp_mem_addr = '0;
    wb_data = {32'h0, 32'hDEAD_BEEF};
    wb_one(0);
    wb_data = '0;
    check_eq("t6_cvalid", commit_valid, 1);
    check_eq("t6_is_store", commit_is_store, 1);
    check_eq("t6_addr", commit_mem_addr, 64'h1000);
    check_eq("t6_data", commit_data, 64'hDEAD_BEEF);
    check_eq("t6_prev", commit_prev_preg, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
